// File: rtl/pq_op_arbiter.sv
// Round-robin push/pop/replace arbiter and single-cycle command sequencer for the hybrid priority queue.
// Define PQ_ARB_STRICT_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module pq_op_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned QUEUE_SIZE = 28,
  parameter int unsigned ISSUE_GAP  = 2,
  localparam int unsigned ID_W      = $clog2(NUM_REQ),
  localparam int unsigned CNT_W     = $clog2(QUEUE_SIZE + 1)
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [2*NUM_REQ-1:0]          i_req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_pq_wrt,
  output logic                          o_pq_read,
  output logic [DATA_WIDTH-1:0]         o_pq_data,
  input  logic [DATA_WIDTH-1:0]         i_pq_data,
  input  logic                          i_pq_full,
  input  logic                          i_pq_empty,
  output logic                          o_rsp_valid,
  output logic [ID_W-1:0]               o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic [CNT_W-1:0]              o_count
);

  localparam int unsigned GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_REPL = 2'b11
  } op_t;

  state_t               state;
  state_t               state_next;
  logic [GAP_W-1:0]     gap_cnt;
  logic [GAP_W-1:0]     gap_next;
  op_t                  cap_op;
  logic [ID_W-1:0]      cap_id;

  logic                 can_push;
  logic                 can_pop;
  logic [NUM_REQ-1:0]   eligible;
  logic                 found;
  logic [ID_W-1:0]      grant_idx;
  logic                 handshake;
  op_t                  grant_op;
  logic [DATA_WIDTH-1:0] grant_data;

`ifndef PQ_ARB_STRICT_PRIO_EN
  logic [ID_W-1:0]      rr_ptr;
`endif

  // Eligibility uses the local count so a freshly issued command is accounted for
  // before the queue's own status flags catch up.
  assign can_push = (o_count < CNT_W'(QUEUE_SIZE)) && !i_pq_full;
  assign can_pop  = (o_count != '0) && !i_pq_empty;

  always_comb begin
    eligible = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      case (op_t'(i_req_op[2*r +: 2]))
        OP_PUSH:         eligible[r] = i_req_valid[r] && can_push;
        OP_POP, OP_REPL: eligible[r] = i_req_valid[r] && can_pop;
        default:         eligible[r] = 1'b0;
      endcase
    end
  end

  always_comb begin
    int unsigned cand;
    cand      = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef PQ_ARB_STRICT_PRIO_EN
      cand = k;
`else
      cand = (32'(rr_ptr) + 1 + k) % NUM_REQ;
`endif
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        grant_idx = ID_W'(cand);
      end
    end
  end

  assign handshake   = (state == IDLE) && found;
  assign o_req_ready = handshake ? (NUM_REQ'(1) << grant_idx) : '0;
  assign grant_op    = op_t'(i_req_op[2*grant_idx +: 2]);
  assign grant_data  = i_req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    unique case (state)
      IDLE: begin
        if (handshake) state_next = ISSUE;
      end
      ISSUE: begin
        if (ISSUE_GAP > 0) begin
          state_next = HOLD;
          gap_next   = GAP_W'(ISSUE_GAP - 1);
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (gap_cnt == '0) state_next = IDLE;
        else               gap_next   = gap_cnt - GAP_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // The command outputs are loaded on the handshake edge so the pulse coincides
  // with the ISSUE state; the response is sampled at the end of ISSUE.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      cap_op      <= OP_NONE;
      cap_id      <= '0;
      o_pq_wrt    <= 1'b0;
      o_pq_read   <= 1'b0;
      o_pq_data   <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_data  <= '0;
      o_count     <= '0;
    end else begin
      state       <= state_next;
      gap_cnt     <= gap_next;
      o_pq_wrt    <= 1'b0;
      o_pq_read   <= 1'b0;
      o_pq_data   <= '0;
      o_rsp_valid <= 1'b0;
      if (handshake) begin
        cap_op    <= grant_op;
        cap_id    <= grant_idx;
        o_pq_wrt  <= grant_op[0];
        o_pq_read <= grant_op[1];
        o_pq_data <= (grant_op == OP_POP) ? '0 : grant_data;
      end
      if (state == ISSUE) begin
        case (cap_op)
          OP_PUSH: o_count <= o_count + CNT_W'(1);
          OP_POP:  o_count <= o_count - CNT_W'(1);
          default: o_count <= o_count;
        endcase
        if (cap_op[1]) begin
          o_rsp_valid <= 1'b1;
          o_rsp_id    <= cap_id;
          o_rsp_data  <= i_pq_data;
        end
      end
    end
  end

`ifdef PQ_ARB_STRICT_PRIO_EN
`else
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)          rr_ptr <= ID_W'(NUM_REQ - 1);
    else if (handshake) rr_ptr <= grant_idx;
  end
`endif

  a_ready_onehot: assert property (@(posedge CLK) disable iff (!RSTn) $onehot0(o_req_ready));
  a_count_bound:  assert property (@(posedge CLK) disable iff (!RSTn) o_count <= CNT_W'(QUEUE_SIZE));

endmodule

// File: doc/pq_op_arbiter.md
# pq_op_arbiter

Operation arbiter and sequencer placed in front of the hybrid priority queue. It accepts push/pop/replace requests from up to NUM_REQ independent requesters, selects one per slot by round-robin, and issues a single-cycle command on the queue's write/read interface. It also enforces a minimum spacing between commands so the pipelined BRAM trees can settle, and returns popped values to the originating requester. The block keeps its own occupancy count, so eligibility never depends on lagging queue status.

## Interface
- DATA_WIDTH, 16, key width; matches the queue.
- NUM_REQ, 4, number of requesters (≥2).
- QUEUE_SIZE, 28, queue capacity in entries.
- ISSUE_GAP, 2, idle cycles inserted after each command (≥0).

- CLK  in  1  clock, rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_op  in  2*NUM_REQ  per-requester op, slice [2r+1:2r]: 01 push, 10 pop, 11 replace, 00 none.
- i_req_data  in  NUM_REQ*DATA_WIDTH  per-requester push/replace key, slice r.
- o_req_ready  out  NUM_REQ  one-hot grant; a handshake occurs when valid&ready.
- o_pq_wrt  out  1  queue write command.
- o_pq_read  out  1  queue read command.
- o_pq_data  out  DATA_WIDTH  queue input key.
- i_pq_data  in  DATA_WIDTH  queue root (head) value.
- i_pq_full  in  1  queue full flag.
- i_pq_empty  in  1  queue empty flag.
- o_rsp_valid  out  1  pop/replace result valid, one cycle.
- o_rsp_id  out  $clog2(NUM_REQ)  requester index of the result.
- o_rsp_data  out  DATA_WIDTH  popped key.
- o_count  out  $clog2(QUEUE_SIZE+1)  local occupancy.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on a handshake.
  - ISSUE → HOLD if ISSUE_GAP>0, otherwise ISSUE → IDLE.
  - HOLD counts down ISSUE_GAP cycles, then → IDLE.
- o_req_ready is nonzero only in IDLE, with at most one bit set.
- Eligibility of requester r (valid must be high):
  - push: o_count<QUEUE_SIZE and !i_pq_full.
  - pop: o_count>0 and !i_pq_empty.
  - replace: same rule as pop; replace on an empty queue is never granted.
  - op 00: never eligible.
- Arbitration:
  - Round-robin among eligible requesters, starting the search at rr_ptr+1 modulo NUM_REQ.
  - rr_ptr loads the granted index on each handshake; ineligible requesters are skipped without losing their turn.
- Grant captures op, data and id into registers.
- ISSUE cycle drives, for exactly one cycle:
  - push: o_pq_wrt=1, o_pq_read=0.
  - pop: o_pq_wrt=0, o_pq_read=1.
  - replace: o_pq_wrt=1, o_pq_read=1.
  - o_pq_data = captured key for push/replace, 0 for pop.
  - For pop/replace, i_pq_data is sampled into o_rsp_data in this cycle (the root being removed).
- o_count update, registered at the end of ISSUE: push +1, pop −1, replace unchanged; no wrap is possible because of the eligibility rules.
- Requests not granted stay pending; requesters must hold op/data stable until their handshake.

## Timing
- Handshake at cycle T; command pulse at T+1; o_rsp_valid/o_rsp_id/o_rsp_data at T+2 for one cycle (pop/replace only).
- Command pulses are spaced at least ISSUE_GAP+2 cycles apart; back-to-back handshakes are spaced the same.
- Simultaneous requests: exactly one is granted; the remainder wait for later IDLE cycles.
- Reset values:
  - All outputs 0; o_count 0; state IDLE.
  - rr_ptr = NUM_REQ−1, so requester 0 wins first.
- Reset mid-operation: any command or response in flight is discarded; no pulse appears after RSTn rises until a new handshake.
- o_pq_* and o_rsp_* are registered outputs; o_req_ready is combinational from the current state, rr_ptr, request inputs and status.

## Configuration
- PQ_ARB_STRICT_PRIO_EN defined: fixed priority replaces round-robin; the lowest-index eligible requester always wins and rr_ptr is unused (held at reset value).
- Not defined: round-robin as specified in Operation.

## Test plan
- Single push, then pop: requester 1 pushes 0x0050, then pops.
  - o_pq_wrt pulses at T+1 with o_pq_data=0x0050.
  - The pop returns o_rsp_data=0x0050, o_rsp_id=1 at T'+2; o_count goes 0→1→0.
- Fairness: all four requesters continuously push distinct keys with ISSUE_GAP=2.
  - Grants occur in order 0,1,2,3,0.
  - Command pulses are exactly 4 cycles apart.
- Boundaries, full: with o_count=28, requester 0 push and requester 2 pop both pending → only requester 2 is granted; the push is granted afterwards.
- Boundaries, empty: with the queue empty, requests for pop and replace receive no ready and no pq pulse.
- Replace: with root 0x0090, a replace with key 0x0010 gives o_pq_wrt=o_pq_read=1 and o_rsp_data=0x0090; o_count is unchanged.
- Reset mid-operation: assert RSTn low in the ISSUE cycle → o_pq_wrt/read drop immediately, no o_rsp_valid appears, and o_count=0.
- Macro build: with PQ_ARB_STRICT_PRIO_EN, requesters 0 and 3 continuously pushing → requester 0 wins every slot.
